drive_enve_addr_gen: RTL

DRIVE_ENVE_ADDR_GEN -- requirements
Module: drive_enve_addr_gen

---
 rtl/drive_enve_addr_gen_pkg.sv | 11 +
 rtl/drive_enve_sample_pipe.sv | 63 ++++++
 rtl/drive_enve_addr_gen.sv | 100 ++++++++++
 3 files changed

// File: rtl/drive_enve_addr_gen_pkg.sv
// rtl/drive_enve_addr_gen_pkg.sv - shared drive-circuit state encoding and width defaults
package drive_enve_addr_gen_pkg;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_READ = 1'b1;

    localparam int ADDR_W_DEF = 10;
    localparam int LEN_W_DEF  = 10;
    localparam int DATA_W_DEF = 16;

endpackage

// File: rtl/drive_enve_sample_pipe.sv
// rtl/drive_enve_sample_pipe.sv - read-data capture pipeline with sample index
module drive_enve_sample_pipe #(
    parameter int LEN_W  = 10,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_read_addr,
    input  logic              rd_en,
    input  logic              fin,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              sample_last,
    output logic [LEN_W-1:0]  sample_idx
);

    logic              rd_en_d1_q, rd_en_d1_d;
    logic              last_d1_q, last_d1_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [LEN_W-1:0]  idx_q, idx_d;

    always_comb begin
        rd_en_d1_d = rd_en;
        // A zero-length envelope pulses fin with no read; keep it out of the sample stream.
        last_d1_d  = fin & rd_en;
        sample_d   = rd_en_d1_q ? rd_data : sample_q;
        valid_d    = rd_en_d1_q;
        last_d     = last_d1_q;
        idx_d      = idx_q;
        if (start_read_addr) begin
            idx_d = '0;
        end else if (valid_q && (idx_q != {LEN_W{1'b1}})) begin
            idx_d = idx_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_d1_q <= 1'b0;
            last_d1_q  <= 1'b0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            idx_q      <= '0;
        end else begin
            rd_en_d1_q <= rd_en_d1_d;
            last_d1_q  <= last_d1_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign sample_last  = last_q;
    assign sample_idx   = idx_q;

endmodule

// File: rtl/drive_enve_addr_gen.sv
// rtl/drive_enve_addr_gen.sv - envelope memory address generator with sample pipeline
import drive_enve_addr_gen_pkg::*;

module drive_enve_addr_gen #(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_read_addr,
    input  logic              set_enve_memory_addr,
    input  logic              increment_enve_memory_addr,
    input  logic [ADDR_W-1:0] enve_start_addr,
    input  logic [LEN_W-1:0]  enve_len,
    input  logic [DATA_W-1:0] enve_mem_rd_data,
    output logic [ADDR_W-1:0] enve_mem_addr,
    output logic              enve_mem_rd_en,
    output logic              is_read_env_fin,
    output logic [DATA_W-1:0] enve_sample,
    output logic              enve_sample_valid,
    output logic              enve_sample_last,
    output logic [LEN_W-1:0]  enve_sample_idx,
    output logic              busy
);

    logic              state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              rd_en_q, rd_en_d;
    logic              fin_q, fin_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        rd_en_d     = 1'b0;
        fin_d       = 1'b0;
        if (set_enve_memory_addr) begin
            if (enve_len != '0) begin
                addr_d      = enve_start_addr;
                remaining_d = enve_len - LEN_W'(1);
                rd_en_d     = 1'b1;
                fin_d       = (enve_len == LEN_W'(1));
                state_d     = STATE_READ;
            end else begin
                fin_d   = 1'b1;
                state_d = STATE_IDLE;
            end
        end else if (state_q == STATE_READ) begin
            // remaining==0 in READ means the last address was issued last cycle.
            if (remaining_q == '0) begin
                state_d = STATE_IDLE;
            end else if (increment_enve_memory_addr) begin
                addr_d      = addr_q + ADDR_W'(1);
                remaining_d = remaining_q - LEN_W'(1);
                rd_en_d     = 1'b1;
                fin_d       = (remaining_q == LEN_W'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= STATE_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            rd_en_q     <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            rd_en_q     <= rd_en_d;
            fin_q       <= fin_d;
        end
    end

    assign enve_mem_addr   = addr_q;
    assign enve_mem_rd_en  = rd_en_q;
    assign is_read_env_fin = fin_q;
    assign busy            = (state_q == STATE_READ);

    drive_enve_sample_pipe #(
        .LEN_W  (LEN_W),
        .DATA_W (DATA_W)
    ) u_pipe (
        .clk             (clk),
        .rst             (rst),
        .start_read_addr (start_read_addr),
        .rd_en           (rd_en_q),
        .fin             (fin_q),
        .rd_data         (enve_mem_rd_data),
        .sample          (enve_sample),
        .sample_valid    (enve_sample_valid),
        .sample_last     (enve_sample_last),
        .sample_idx      (enve_sample_idx)
    );

endmodule
